// File: rtl/accel_seq_if.sv
// Request, bus-arbitration, ack and completion-queue signals of the accelerator sequencer.
// The master modport is the environment side; the slave modport is the sequencer.
interface accel_seq_if #(
  parameter int ADDRW  = 24,
  parameter int NUM_RD = 2
);
  localparam int RW = (NUM_RD + 1) * ADDRW + 2;

  logic              req_valid;
  logic [RW-1:0]     req_data;
  logic              ready_req_out;
  logic              arb_req;
  logic              arb_grant;
  logic [2:0]        ack_in;
  logic [ADDRW+7:0]  data_out;
  logic              compq_ready_in;
  logic              valid_compq_out;
  logic [ADDRW:0]    compq_data_out;

  modport master (
    output req_valid, req_data, arb_grant, ack_in, compq_ready_in,
    input  ready_req_out, arb_req, data_out, valid_compq_out, compq_data_out
  );

  modport slave (
    input  req_valid, req_data, arb_grant, ack_in, compq_ready_in,
    output ready_req_out, arb_req, data_out, valid_compq_out, compq_data_out
  );
endinterface

// File: rtl/accel_seq_fsm.sv
// Sequences one accelerator job: NUM_RD memory reads, an accelerator op, a memory write,
// then posts {err, dst} to the completion queue. Every ack wait has an optional timeout.
module accel_seq_fsm #(
  parameter int         ADDRW       = 24,
  parameter logic [1:0] ACCEL_ID    = 2'b01,
  parameter logic [1:0] MEM_ID      = 2'b00,
  parameter int         NUM_RD      = 2,
  parameter int         ACK_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  accel_seq_if.slave  bus
);
  localparam int RW = (NUM_RD + 1) * ADDRW + 2;
  localparam int TW = $clog2(ACK_TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, OP_REQ, OP_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   req_reg, req_next;
  logic [1:0]      rd_idx_reg, rd_idx_next;
  logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic            err_reg, err_next;

  logic [ADDRW-1:0] src [4];
  logic [ADDRW-1:0] dst;
  logic             mode;
  logic             ack_mem, ack_accel, tmo_hit, in_wait;

  // Four source slots so a 2-bit rd_idx always indexes in range; unused slots read zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    if (gi < NUM_RD) begin : g_used
      assign src[gi] = req_reg[(gi+2)*ADDRW-1 -: ADDRW];
    end else begin : g_unused
      assign src[gi] = '0;
    end
  end

  assign dst       = req_reg[ADDRW-1:0];
  assign mode      = req_reg[RW-2];
  assign ack_mem   = (bus.ack_in == {1'b1, MEM_ID});
  assign ack_accel = (bus.ack_in == {1'b1, ACCEL_ID});
  assign tmo_hit   = (ACK_TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST);
  assign in_wait   = (state_reg == RD_WAIT) || (state_reg == OP_WAIT) || (state_reg == WR_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      req_reg     <= '0;
      rd_idx_reg  <= '0;
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      rd_idx_reg  <= rd_idx_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    req_next            = req_reg;
    rd_idx_next         = rd_idx_reg;
    err_next            = err_reg;
    bus.ready_req_out   = 1'b0;
    bus.arb_req         = 1'b0;
    bus.data_out        = '0;
    bus.valid_compq_out = 1'b0;
    bus.compq_data_out  = '0;

    case (state_reg)
      IDLE: begin
        bus.ready_req_out = 1'b1;
        if (bus.req_valid) begin
          req_next    = bus.req_data;
          rd_idx_next = '0;
          err_next    = 1'b0;
          state_next  = RD_REQ;
        end
      end
      RD_REQ, RD_WAIT: begin
        bus.data_out = {src[rd_idx_reg], 2'b00, ACCEL_ID, MEM_ID, 2'b01};
        if (state_reg == RD_REQ) begin
          bus.arb_req = 1'b1;
          if (bus.arb_grant) state_next = RD_WAIT;
        end else if (ack_mem) begin
          if (rd_idx_reg < 2'(NUM_RD - 1)) begin
            rd_idx_next = rd_idx_reg + 2'd1;
            state_next  = RD_REQ;
          end else begin
            state_next  = OP_REQ;
          end
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      OP_REQ, OP_WAIT: begin
        bus.data_out = {{ADDRW{1'b0}}, mode, 1'b0, ACCEL_ID, 4'b0011};
        if (state_reg == OP_REQ) begin
          bus.arb_req = 1'b1;
          if (bus.arb_grant) state_next = OP_WAIT;
        end else if (ack_accel) begin
          state_next = WR_REQ;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      WR_REQ, WR_WAIT: begin
        bus.data_out = {dst, 2'b00, MEM_ID, ACCEL_ID, 2'b10};
        if (state_reg == WR_REQ) begin
          bus.arb_req = 1'b1;
          if (bus.arb_grant) state_next = WR_WAIT;
        end else if (ack_mem) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.valid_compq_out = 1'b1;
        bus.compq_data_out  = {err_reg, dst};
        if (bus.compq_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts whenever a wait state is entered, counts only while staying in it.
  always_comb begin
    tmo_cnt_next = '0;
    if (in_wait && (state_next == state_reg)) tmo_cnt_next = tmo_cnt_reg + 1'b1;
  end
endmodule
